ex_mem: RTL and testbench
=========================

Name: ex_mem

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage OpenMIPS core.
- Latches execute results (GPR write info, HI/LO write info) on each clock edge and presents them to the memory-access stage.
- Honours the global stall vector, inserting bubbles or holding as required.
- Carries the multi-cycle accumulate state (64-bit partial product plus cycle counter) that execute needs for two-cycle madd/maddu/msub/msubu while execute is stalled.

Parameters:
- REG_W, 32, GPR/HI/LO data width (matches `RegBus`).
- REGADDR_W, 5, GPR address width (matches `RegAddrBus`).
- STALL_W, 6, stall vector width. Bits: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high (`RstEnable` = 1'b1).
- stall  in  STALL_W  global stall vector from ctrl; `Stop` = 1.
- flush  in  1  pipeline flush; clears the stage, same effect as reset.
- ex_wd  in  REGADDR_W  destination GPR address from execute.
- ex_wreg  in  1  GPR write enable from execute.
- ex_wdata  in  REG_W  GPR write data from execute.
- ex_hi  in  REG_W  HI write value.
- ex_lo  in  REG_W  LO write value.
- ex_whilo  in  1  HI/LO write enable.
- hilo_i  in  2*REG_W  partial product/accumulate value produced by execute in cycle 1 of a madd/msub.
- cnt_i  in  2  execute's multi-cycle counter value (0 or 1).
- mem_wd  out  REGADDR_W  latched destination address.
- mem_wreg  out  1  latched GPR write enable.
- mem_wdata  out  REG_W  latched GPR data.
- mem_hi  out  REG_W  latched HI value.
- mem_lo  out  REG_W  latched LO value.
- mem_whilo  out  1  latched HI/LO write enable.
- hilo_o  out  2*REG_W  stored partial value returned to execute.
- cnt_o  out  2  stored counter returned to execute.

Behaviour:
- Registered outputs only. One-cycle latency from execute inputs to mem_* outputs. There is no combinational path from inputs to outputs.
- Priority on each rising clk edge, highest first:
  1. rst==1: all outputs cleared. mem_wd=`NOPRegAddr` (0), mem_wreg=0, mem_wdata=0, mem_hi=0, mem_lo=0, mem_whilo=0, hilo_o=0, cnt_o=0.
  2. flush==1: same values as reset. This aborts any in-progress madd (cnt_o returns to 0).
  3. stall[3]==Stop and stall[4]==NoStop (bubble): all mem_* outputs set to reset values, so the mem stage sees a NOP. hilo_o<=hilo_i and cnt_o<=cnt_i, so the held execute instruction resumes its accumulate next cycle.
  4. stall[3]==NoStop (advance): mem_* outputs <= ex_* inputs. hilo_o<=0 and cnt_o<=0, because the instruction has left execute and the temp state is retired.
  5. Otherwise (stall[3] and stall[4] both Stop): hold all outputs. hilo_o/cnt_o hold as well.
- Effective accumulate sequence for a two-cycle madd:
  - Cycle A: execute requests a stall, drives cnt_i=1 and hilo_i=product. Case 3 applies and the values are captured.
  - Cycle B: execute sees cnt_o=1, computes the final HI/LO, drops its stall request. Case 4 applies.
- stall[4]==Stop with stall[3]==NoStop is illegal from ctrl. Treat it as case 4; the bench asserts it never occurs.
- rst or flush arriving mid-accumulate (cnt_o=1) clears cnt_o to 0 on that edge.
- hilo_o is full 64 bits; no truncation. cnt_o upper bit is always 0 in current use and is reserved.

Decomposition:
- Shared defines file holds: `RstEnable`, `Stop`/`NoStop`, `ZeroWord`, `NOPRegAddr`, `WriteDisable`, `RegBus`, `RegAddrBus`, `DoubleRegBus`.
- A sub-module is not warranted. One always block with the priority chain above is sufficient.

Test Plan:
- Reset: drive rst=1 with all ex_* inputs non-zero (ex_wd=5'h1F, ex_wdata=32'hDEADBEEF, cnt_i=1) for one edge -> all outputs 0.
- Advance: stall=6'b000000, ex_wd=3, ex_wreg=1, ex_wdata=32'h0000_1234 -> next edge mem_wd=3, mem_wreg=1, mem_wdata=32'h1234, cnt_o=0.
- Bubble with accumulate: stall=6'b001111, hilo_i=64'h0000_0001_0000_0002, cnt_i=1, ex_wreg=1 -> mem_wreg=0, mem_wd=0, hilo_o=64'h1_0000_0002, cnt_o=1. Next edge with stall=0 and ex_whilo=1, ex_hi=1, ex_lo=5 -> mem_whilo=1, mem_hi=1, mem_lo=5, hilo_o=0, cnt_o=0.
- Hold: load mem_wdata=32'hA5A5A5A5, then stall=6'b011111 for 3 cycles while ex_wdata changes -> mem_wdata stays 32'hA5A5A5A5 and cnt_o/hilo_o are unchanged.
- Flush mid-accumulate: cnt_o=1 and hilo_o nonzero, then flush=1 with stall=6'b001111 -> all outputs 0 on that edge.
- Reset priority: rst=1 and flush=1 and stall=0 with valid ex_* inputs -> outputs 0. Releasing rst resumes normal advance on the following edge.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared constants and helpers for the EX/MEM pipeline register.
package ex_mem_pkg;

  // Default widths (GPR/HI/LO data, GPR address, stall vector)
  localparam int REG_W_DEF     = 32;
  localparam int REGADDR_W_DEF = 5;
  localparam int STALL_W_DEF   = 6;

  // Stall vector bit positions owned by the execute and memory stages
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic RST_ENABLE = 1'b1;

  // What the register does on the coming edge
  typedef enum logic [1:0] {
    ACT_CLEAR,    // reset or flush: everything to zero
    ACT_BUBBLE,   // ex held, mem runs: NOP into mem, keep accumulate state
    ACT_ADVANCE,  // ex result moves to mem, accumulate state retired
    ACT_HOLD      // ex and mem both held: freeze
  } stage_act_e;

  // Priority: reset, flush, bubble, advance, hold.
  // mem stalled with ex running cannot come from ctrl; it falls into advance.
  function automatic stage_act_e decode_act(input logic rst, input logic flush,
                                            input logic ex_stall, input logic mem_stall);
    if (rst == RST_ENABLE || flush)                  return ACT_CLEAR;
    if (ex_stall == STOP && mem_stall == NO_STOP)    return ACT_BUBBLE;
    if (ex_stall == NO_STOP)                         return ACT_ADVANCE;
    return ACT_HOLD;
  endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: latches execute results for the memory stage and
// carries the madd/msub partial product across the execute stall cycle.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int REG_W     = REG_W_DEF,
  parameter int REGADDR_W = REGADDR_W_DEF,
  parameter int STALL_W   = STALL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic [REGADDR_W-1:0] ex_wd,
  input  logic                 ex_wreg,
  input  logic [REG_W-1:0]     ex_wdata,
  input  logic [REG_W-1:0]     ex_hi,
  input  logic [REG_W-1:0]     ex_lo,
  input  logic                 ex_whilo,
  input  logic [2*REG_W-1:0]   hilo_i,
  input  logic [1:0]           cnt_i,
  output logic [REGADDR_W-1:0] mem_wd,
  output logic                 mem_wreg,
  output logic [REG_W-1:0]     mem_wdata,
  output logic [REG_W-1:0]     mem_hi,
  output logic [REG_W-1:0]     mem_lo,
  output logic                 mem_whilo,
  output logic [2*REG_W-1:0]   hilo_o,
  output logic [1:0]           cnt_o
);

  stage_act_e act;

  // Only the ex and mem stall bits matter to this register.
  logic unused_stall;
  assign unused_stall = ^{stall[STALL_W-1:STALL_MEM+1], stall[STALL_EX-1:0]};

  // Decode this edge's action from reset, flush and the ex/mem stall bits.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    act = ACT_HOLD;
    act = decode_act(rst, flush, stall[STALL_EX], stall[STALL_MEM]);
  end

  // Update the mem-facing outputs and the accumulate state per the decoded action.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    unique case (act)
      ACT_CLEAR: begin
        mem_wd    <= '0;
        mem_wreg  <= 1'b0;
        mem_wdata <= '0;
        mem_hi    <= '0;
        mem_lo    <= '0;
        mem_whilo <= 1'b0;
        hilo_o    <= '0;
        cnt_o     <= 2'd0;
      end
      ACT_BUBBLE: begin
        mem_wd    <= '0;
        mem_wreg  <= 1'b0;
        mem_wdata <= '0;
        mem_hi    <= '0;
        mem_lo    <= '0;
        mem_whilo <= 1'b0;
        hilo_o    <= hilo_i;
        cnt_o     <= cnt_i;
      end
      ACT_ADVANCE: begin
        mem_wd    <= ex_wd;
        mem_wreg  <= ex_wreg;
        mem_wdata <= ex_wdata;
        mem_hi    <= ex_hi;
        mem_lo    <= ex_lo;
        mem_whilo <= ex_whilo;
        hilo_o    <= '0;
        cnt_o     <= 2'd0;
      end
      default: ;  // ACT_HOLD: every register keeps its value
    endcase
  end

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: reset, advance, bubble/accumulate, hold, flush,
// reset priority.
module tb_ex_mem;

  localparam int OUT_W = 5 + 1 + 32 + 32 + 32 + 1 + 64 + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic        ex_whilo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int compared   = 0;
  int mismatched = 0;

  logic [OUT_W-1:0] exp_v;
  logic [OUT_W-1:0] obs_v;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  // ctrl never stalls mem while letting ex run
  always @(posedge clk)
    if (rst !== 1'b1)
      assert (!(stall[4] === 1'b1 && stall[3] === 1'b0))
        else $error("illegal stall vector %b", stall);

  function automatic logic [OUT_W-1:0] pack(input logic [4:0] wd, input logic wreg,
                                            input logic [31:0] wdata, input logic [31:0] hi,
                                            input logic [31:0] lo, input logic whilo,
                                            input logic [63:0] hilo, input logic [1:0] cnt);
    return {wd, wreg, wdata, hi, lo, whilo, hilo, cnt};
  endfunction

  task automatic sample();
    obs_v = pack(mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic drive_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
                          input logic [63:0] hilo, input logic [1:0] cnt);
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_hi = hi; ex_lo = lo;
    ex_whilo = whilo; hilo_i = hilo; cnt_i = cnt;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; stall = 6'b000000;
    drive_ex(5'h1F, 1'b1, 32'hDEADBEEF, 32'h1111_2222, 32'h3333_4444, 1'b1,
             64'hFFFF_0000_FFFF_0000, 2'd1);
    step();
    exp_v = '0;
    compared++;
    if (obs_v !== exp_v) begin
      mismatched++;
      $display("FAIL reset: got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_advance();
    rst = 1'b0; stall = 6'b000000;
    drive_ex(5'd3, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 64'h0000_0000_0000_FFFF, 2'd1);
    step();
    exp_v = pack(5'd3, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);
    compared++;
    if (obs_v !== exp_v) begin
      mismatched++;
      $display("FAIL advance_gpr: got %h want %h", obs_v, exp_v);
    end
    drive_ex(5'h1F, 1'b0, 32'hFFFF_FFFF, 32'hAAAA_5555, 32'h0000_0001, 1'b1, 64'h1, 2'd0);
    step();
    exp_v = pack(5'h1F, 1'b0, 32'hFFFF_FFFF, 32'hAAAA_5555, 32'h0000_0001, 1'b1, 64'h0, 2'd0);
    compared++;
    if (obs_v !== exp_v) begin
      mismatched++;
      $display("FAIL advance_hilo: got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_bubble_accumulate();
    stall = 6'b001111;
    drive_ex(5'd7, 1'b1, 32'h0000_0099, 32'h7, 32'h8, 1'b1, 64'h0000_0001_0000_0002, 2'd1);
    step();
    exp_v = pack(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h0000_0001_0000_0002, 2'd1);
    compared++;
    if (obs_v !== exp_v) begin
      mismatched++;
      $display("FAIL bubble_capture: got %h want %h", obs_v, exp_v);
    end
    stall = 6'b000000;
    drive_ex(5'd0, 1'b0, 32'h0, 32'h0000_0001, 32'h0000_0005, 1'b1, 64'h0, 2'd0);
    step();
    exp_v = pack(5'd0, 1'b0, 32'h0, 32'h0000_0001, 32'h0000_0005, 1'b1, 64'h0, 2'd0);
    compared++;
    if (obs_v !== exp_v) begin
      mismatched++;
      $display("FAIL bubble_finish: got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_hold();
    // Hold of freshly advanced mem outputs
    stall = 6'b000000;
    drive_ex(5'd2, 1'b1, 32'hA5A5_A5A5, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);
    step();
    exp_v = pack(5'd2, 1'b1, 32'hA5A5_A5A5, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);
    compared++;
    if (obs_v !== exp_v) begin
      mismatched++;
      $display("FAIL hold_load: got %h want %h", obs_v, exp_v);
    end
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      drive_ex(5'(9 + i), 1'b0, 32'h1000_0000 + 32'(i), 32'(i), 32'(i), 1'b1,
               64'h5555_0000_0000_0000 + 64'(i), 2'd1);
      step();
      compared++;
      if (obs_v !== exp_v) begin
        mismatched++;
        $display("FAIL hold_gpr[%0d]: got %h want %h", i, obs_v, exp_v);
      end
    end
    // Hold of captured accumulate state
    stall = 6'b001111;
    drive_ex(5'd4, 1'b1, 32'h4, 32'h4, 32'h4, 1'b1, 64'hCAFE_F00D_1234_5678, 2'd1);
    step();
    exp_v = pack(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'hCAFE_F00D_1234_5678, 2'd1);
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      drive_ex(5'd6, 1'b1, 32'hBBBB_0000 + 32'(i), 32'h1, 32'h2, 1'b1, 64'(i), 2'd0);
      step();
      compared++;
      if (obs_v !== exp_v) begin
        mismatched++;
        $display("FAIL hold_acc[%0d]: got %h want %h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_flush();
    stall = 6'b001111;
    drive_ex(5'd8, 1'b1, 32'h8, 32'h8, 32'h8, 1'b1, 64'hDEAD_BEEF_0123_4567, 2'd1);
    step();
    exp_v = pack(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'hDEAD_BEEF_0123_4567, 2'd1);
    compared++;
    if (obs_v !== exp_v) begin
      mismatched++;
      $display("FAIL flush_setup: got %h want %h", obs_v, exp_v);
    end
    flush = 1'b1;
    drive_ex(5'd8, 1'b1, 32'h8, 32'h8, 32'h8, 1'b1, 64'h1234_0000_0000_9999, 2'd1);
    step();
    exp_v = '0;
    compared++;
    if (obs_v !== exp_v) begin
      mismatched++;
      $display("FAIL flush_mid_acc: got %h want %h", obs_v, exp_v);
    end
    stall = 6'b000000;
    drive_ex(5'd12, 1'b1, 32'h7777_7777, 32'h1, 32'h2, 1'b1, 64'h3, 2'd0);
    step();
    compared++;
    if (obs_v !== exp_v) begin
      mismatched++;
      $display("FAIL flush_advance: got %h want %h", obs_v, exp_v);
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; flush = 1'b1; stall = 6'b000000;
    drive_ex(5'd17, 1'b1, 32'h0BAD_F00D, 32'h5, 32'h6, 1'b1, 64'h9, 2'd1);
    step();
    exp_v = '0;
    compared++;
    if (obs_v !== exp_v) begin
      mismatched++;
      $display("FAIL rst_priority: got %h want %h", obs_v, exp_v);
    end
    rst = 1'b0; flush = 1'b0;
    step();
    exp_v = pack(5'd17, 1'b1, 32'h0BAD_F00D, 32'h5, 32'h6, 1'b1, 64'h0, 2'd0);
    compared++;
    if (obs_v !== exp_v) begin
      mismatched++;
      $display("FAIL rst_release: got %h want %h", obs_v, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_advance();
    test_bubble_accumulate();
    test_hold();
    test_flush();
    test_reset_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
